// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: pin sync, clock deglitch,
// 11-bit frame deframing and E0/F0 prefix folding.
module ps2_keyboard #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       kdone,
  output logic [7:0] kdata,
  output logic       kext,
  output logic       krel,
  output logic       kerr
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]    csync;
  logic [1:0]    dsync;
  logic          fclk;
  logic          fclk_d;
  logic [7:0]    fcnt;
  logic          fall;
  logic          din;
  logic [1:0]    state;
  logic [2:0]    cnt;
  logic [7:0]    sh;
  logic          par;
  logic          ext_pend;
  logic          rel_pend;
  logic [TW-1:0] tcnt;

  // two-flop synchronisers for both pins, idle high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csync <= 2'b11;
      dsync <= 2'b11;
    end else begin
      csync <= {csync[0], ps2_clk};
      dsync <= {dsync[0], ps2_data};
    end
  end

  // filtered clock follows only a level held FILTER cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fclk   <= 1'b1;
      fclk_d <= 1'b1;
      fcnt   <= 8'd0;
    end else begin
      fclk_d <= fclk;
      if (csync[1] != fclk) begin
        if (fcnt == 8'(FILTER - 1)) begin
          fclk <= csync[1];
          fcnt <= 8'd0;
        end else begin
          fcnt <= fcnt + 8'd1;
        end
      end else begin
        fcnt <= 8'd0;
      end
    end
  end

  assign fall = fclk_d & ~fclk;
  assign din  = dsync[1];

  // frame FSM, watchdog, prefix folding and output strobes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      sh       <= 8'd0;
      par      <= 1'b0;
      ext_pend <= 1'b0;
      rel_pend <= 1'b0;
      tcnt     <= '0;
      kdone    <= 1'b0;
      kerr     <= 1'b0;
      kdata    <= 8'd0;
      kext     <= 1'b0;
      krel     <= 1'b0;
    end else begin
      kdone <= 1'b0;
      kerr  <= 1'b0;
      if (state == IDLE) begin
        tcnt <= '0;
        if (fall && !din) begin
          state <= DATA;
          cnt   <= 3'd0;
        end
      end else if (fall) begin
        tcnt <= '0;
        unique case (state)
          DATA: begin
            sh[cnt] <= din;
            cnt     <= cnt + 3'd1;
            if (cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= din;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (din && (^{sh, par})) begin
              if (sh == 8'hE0) begin
                ext_pend <= 1'b1;
              end else if (sh == 8'hF0) begin
                rel_pend <= 1'b1;
              end else begin
                kdata    <= sh;
                kext     <= ext_pend;
                krel     <= rel_pend;
                kdone    <= 1'b1;
                ext_pend <= 1'b0;
                rel_pend <= 1'b0;
              end
            end else begin
              kerr     <= 1'b1;
              ext_pend <= 1'b0;
              rel_pend <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (tcnt == TW'(TIMEOUT - 1)) begin
        state    <= IDLE;
        tcnt     <= '0;
        kerr     <= 1'b1;
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Randomised bench for ps2_keyboard with a queue-based
// event model and a per-cycle output compare.
module tb_ps2_keyboard;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 1000;
  localparam int H       = 30;

  logic       clock;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       kdone;
  logic [7:0] kdata;
  logic       kext;
  logic       krel;
  logic       kerr;

  ps2_keyboard #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kdone(kdone), .kdata(kdata), .kext(kext),
    .krel(krel), .kerr(kerr)
  );

  typedef struct {
    bit         err;
    logic [7:0] d;
    bit         e;
    bit         r;
    bit         tmo;
    int         t0;
  } ev_t;

  ev_t        q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_fall = 0;
  bit         ext_pend = 0;
  bit         rel_pend = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_ext = 0;
  bit         m_rel = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #(900000 * 1ns);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic bit_cycle(input logic b, input bit gl);
    @(negedge clock);
    ps2_data = b;
    if (gl) begin
      repeat (15) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clock);
      ps2_clk = 1'b1;
      repeat (H - 18) @(negedge clock);
    end else begin
      repeat (H) @(negedge clock);
    end
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  task automatic push_frame(input logic [7:0] b, input bit good);
    ev_t ev;
    ev = '{err: 1'b0, d: b, e: ext_pend, r: rel_pend,
           tmo: 1'b0, t0: 0};
    if (!good) begin
      ev.err = 1'b1;
      q.push_back(ev);
      ext_pend = 0;
      rel_pend = 0;
    end else if (b == 8'hE0) begin
      ext_pend = 1;
    end else if (b == 8'hF0) begin
      rel_pend = 1;
    end else begin
      q.push_back(ev);
      ext_pend = 0;
      rel_pend = 0;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit bpar,
                      input bit bstop, input int nbits,
                      input bit gl, input bit abort);
    logic [10:0] f;
    ev_t ev;
    f = {~bstop, (~^b) ^ bpar, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == 10) push_frame(b, !bpar && !bstop);
      bit_cycle(f[i], gl);
    end
    if (nbits < 11 && !abort) begin
      ev = '{err: 1'b1, d: 8'h00, e: 1'b0, r: 1'b0,
             tmo: 1'b1, t0: last_fall};
      q.push_back(ev);
      ext_pend = 0;
      rel_pend = 0;
      repeat (TIMEOUT + 40) @(negedge clock);
    end else if (!abort) begin
      repeat (H) @(negedge clock);
    end
  endtask

  always begin : cmp
    ev_t ev;
    int dt;
    int nom;
    @(posedge clock);
    #1;
    if (!reset_n) begin
      chk("rst_out", {kdone, kerr, kdata, kext, krel}, 32'h0);
      m_data = 8'h00;
      m_ext = 0;
      m_rel = 0;
    end else begin
      if (kdone || kerr) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected kdone=%0b kerr=%0b cyc %0d",
                   kdone, kerr, cyc);
        end else begin
          ev = q.pop_front();
          chk("ev_kind", {kdone, kerr},
              ev.err ? 32'h1 : 32'h2);
          if (ev.tmo) begin
            dt = cyc - ev.t0;
            nom = 3 + FILTER + TIMEOUT;
            checks++;
            if (dt < nom - 1 || dt > nom + 1) begin
              errors++;
              $display("FAIL tmo_lat got %0d exp %0d+-1", dt, nom);
            end
          end
          if (!ev.err) begin
            m_data = ev.d;
            m_ext = ev.e;
            m_rel = ev.r;
          end
        end
      end
      chk("kdata", kdata, m_data);
      chk("kext", kext, m_ext);
      chk("krel", krel, m_rel);
    end
  end

  initial begin
    logic [7:0] b;
    int r;
    int nb;
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clock);
    chk("lit_reset", {kdone, kerr, kdata, kext, krel}, 32'h0);
    reset_n = 1'b1;
    repeat (H) @(negedge clock);

    send(8'h1C, 0, 0, 11, 0, 0);
    chk("lit_make", {kdata, kext, krel}, {22'h0, 8'h1C, 2'b00});

    send(8'hE0, 0, 0, 11, 0, 0);
    send(8'hF0, 0, 0, 11, 0, 0);
    chk("lit_prefix_hold", kdata, 8'h1C);
    send(8'h6B, 0, 0, 11, 0, 0);
    chk("lit_extrel", {kdata, kext, krel}, {22'h0, 8'h6B, 2'b11});
    send(8'h1C, 0, 0, 11, 0, 0);
    chk("lit_after", {kdata, kext, krel}, {22'h0, 8'h1C, 2'b00});

    send(8'h1C, 1, 0, 11, 0, 0);
    chk("lit_par_hold", kdata, 8'h1C);
    send(8'h32, 0, 0, 11, 0, 0);
    chk("lit_32", kdata, 8'h32);

    send(8'h00, 0, 0, 5, 0, 0);
    send(8'h29, 0, 0, 11, 0, 0);
    chk("lit_29", kdata, 8'h29);

    send(8'h45, 0, 0, 11, 1, 0);
    chk("lit_glitch", kdata, 8'h45);

    send(8'hF0, 0, 0, 11, 0, 0);
    send(8'h77, 0, 0, 5, 0, 1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("lit_async", {kdone, kerr, kdata, kext, krel}, 32'h0);
    q.delete();
    ext_pend = 0;
    rel_pend = 0;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    repeat (H) @(negedge clock);
    send(8'h16, 0, 0, 11, 0, 0);
    chk("lit_16", {kdata, krel}, {23'h0, 8'h16, 1'b0});

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      if ($urandom_range(0, 14) == 0) begin
        nb = $urandom_range(1, 10);
        send(b, 0, 0, nb, 0, 0);
      end else begin
        send(b, $urandom_range(0, 9) == 0,
             $urandom_range(0, 11) == 0, 11,
             $urandom_range(0, 3) == 0, 0);
      end
    end

    repeat (200) @(negedge clock);
    chk("q_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
